// File: rtl/jkff_bank_sequencer.sv
// Command-driven sequencer for a bank of JK flip-flops: LOAD, TOGGLE, COUNT, CLEAR.
// The bank is updated only through its J/K drives; WIDTH supports 2..8.
//
// state   | meaning
// --------+-----------------------------------------------------
// S_IDLE  | waiting for a command, cmd_ready high, J=K=0
// S_APPLY | single cycle of LOAD/TOGGLE/CLEAR drive on the bank
// S_COUNT | one synchronous up-count per cycle, r_steps counts down
// S_DONE  | one-cycle completion pulse, J=K=0
module jkff_bank_sequencer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [3:0]       cmd_steps,
    output logic [WIDTH-1:0] j_o,
    output logic [WIDTH-1:0] k_o,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_APPLY = 2'd1,
        S_COUNT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [1:0] OP_LOAD   = 2'b00;
    localparam logic [1:0] OP_TOGGLE = 2'b01;
    localparam logic [1:0] OP_COUNT  = 2'b10;
    localparam logic [1:0] OP_CLEAR  = 2'b11;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [1:0]       r_op;
    logic [WIDTH-1:0] r_data;
    logic [3:0]       r_steps;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_j;
    logic [WIDTH-1:0] w_k;
    logic [WIDTH-1:0] w_carry;
    logic             w_accept;

    assign w_accept = (r_state == S_IDLE) && cmd_valid;

    // Bit i toggles on an increment when every lower bit is already one.
    always_comb begin
        logic v_all_ones;
        v_all_ones = 1'b1;
        w_carry    = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_carry[i] = v_all_ones;
            v_all_ones = v_all_ones & r_q[i];
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_j         = '0;
        w_k         = '0;
        case (r_state)
            S_IDLE: begin
                if (cmd_valid) begin
                    if (cmd_op == OP_COUNT) begin
                        w_state_nxt = (cmd_steps == 4'd0) ? S_DONE : S_COUNT;
                    end else begin
                        w_state_nxt = S_APPLY;
                    end
                end
            end
            S_APPLY: begin
                case (r_op)
                    OP_LOAD: begin
                        w_j = r_data;
                        w_k = ~r_data;
                    end
                    OP_TOGGLE: begin
                        w_j = r_data;
                        w_k = r_data;
                    end
                    OP_CLEAR: begin
                        w_k = '1;
                    end
                    default: begin
                    end
                endcase
                w_state_nxt = S_DONE;
            end
            S_COUNT: begin
                w_j = w_carry;
                w_k = w_carry;
                if (r_steps == 4'd1) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_q     <= '0;
            r_op    <= OP_LOAD;
            r_data  <= '0;
            r_steps <= '0;
        end else begin
            r_q <= (w_j & ~r_q) | (~w_k & r_q);
            if (w_accept) begin
                r_op    <= cmd_op;
                r_data  <= cmd_data;
                r_steps <= cmd_steps;
            end else if (r_state == S_COUNT) begin
                r_steps <= r_steps - 4'd1;
            end
        end
    end

    assign j_o       = w_j;
    assign k_o       = w_k;
    assign q         = r_q;
    assign qb        = ~r_q;
    assign cmd_ready = (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_DONE);

endmodule
